slice_chi_stage: RTL and testbench

- Sequential stage directly downstream of the 25-bit slice permutation (swap) block.
- Consumes one frame of SLICES permuted 25-bit slices (a 5x5 bit plane each), applies the nonlinear row mix, and optionally injects the round-constant bit.
- Hands each result to the write-out/register stage over a valid/ready handshake and signals end of frame.

---
 rtl/chi_pkg.sv | 17 +
 rtl/slice_chi_stage_if.sv | 30 +++
 rtl/chi_row.sv | 14 +
 rtl/slice_chi_stage.sv | 115 +++++++++++
 tb/tb_slice_chi_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/chi_pkg.sv
// Shared constants and FSM state encoding for the slice chi stage.
// The row-mix sub-module and the stage top both import this package.
package chi_pkg;

   localparam int LINE_W   = 25;
   localparam int ROW_W    = 5;
   localparam int ROWS     = 5;
   localparam int IOTA_BIT = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/slice_chi_stage_if.sv
// Handshake bundle between the slice permutation front end (master) and the chi stage (slave).
// It carries frame start, the input slice stream, the output slice stream and the frame status.
interface slice_chi_stage_if #(
   parameter int CNT_W = 6
);
   import chi_pkg::*;

   logic              start;
   logic [LINE_W-1:0] in_line;
   logic              in_valid;
   logic              in_ready;
   logic [LINE_W-1:0] out_line;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [CNT_W-1:0]  slice_idx;
   logic              busy;
   logic              frame_done;

   modport master (
      output start, in_line, in_valid, out_ready,
      input  in_ready, out_line, out_valid, out_last, slice_idx, busy, frame_done
   );

   modport slave (
      input  start, in_line, in_valid, out_ready,
      output in_ready, out_line, out_valid, out_last, slice_idx, busy, frame_done
   );

endinterface

// File: rtl/chi_row.sv
// Nonlinear row mix for one 5-bit row of a slice.
// Column indices wrap within the row.
module chi_row
   import chi_pkg::*;
(
   input  logic [ROW_W-1:0] i_row,
   output logic [ROW_W-1:0] o_row
);

   for (genvar c = 0; c < ROW_W; c++) begin : g_col
      assign o_row[c] = i_row[c] ^ (~i_row[(c + 1) % ROW_W] & i_row[(c + 2) % ROW_W]);
   end

endmodule

// File: rtl/slice_chi_stage.sv
// Chi stage: takes one frame of permuted slices, applies the row mix and registers each result.
// Optional macro CHI_IOTA_EN adds the rc port and XORs rc[z] into bit IOTA_BIT of slice z.
module slice_chi_stage
   import chi_pkg::*;
#(
   parameter int SLICES = 64,
   parameter int CNT_W  = 6
) (
   input logic                clk,
   input logic                rst,
`ifdef CHI_IOTA_EN
   input logic [SLICES-1:0]   rc,
`endif
   slice_chi_stage_if.slave   bus
);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [LINE_W-1:0] r_out_line;
   logic              r_out_valid;
   logic              r_out_last;
   logic [CNT_W-1:0]  r_slice_idx;

   logic [LINE_W-1:0] w_chi;
   logic [LINE_W-1:0] w_next_line;
   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_last_in;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      chi_row u_chi_row (
         .i_row (bus.in_line[r*ROW_W +: ROW_W]),
         .o_row (w_chi[r*ROW_W +: ROW_W])
      );
   end

`ifdef CHI_IOTA_EN
   logic [SLICES-1:0] r_rc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rc <= '0;
      end else if (r_state == IDLE && bus.start) begin
         r_rc <= rc;
      end
   end

   // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
   always_comb begin
      w_next_line           = w_chi;
      w_next_line[IOTA_BIT] = w_chi[IOTA_BIT] ^ r_rc[r_cnt];
   end
`else
   assign w_next_line = w_chi;
`endif

   assign w_in_ready = (r_state == RUN) && (!r_out_valid || bus.out_ready);
   assign w_in_fire  = w_in_ready && bus.in_valid;
   assign w_out_fire = r_out_valid && bus.out_ready;
   assign w_last_in  = (r_cnt == CNT_W'(SLICES - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_out_line  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_slice_idx <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state <= RUN;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               // A new accept overrides a concurrent output handshake: out_valid stays high.
               if (w_in_fire) begin
                  r_out_line  <= w_next_line;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_last_in;
                  r_slice_idx <= r_cnt;
                  if (w_last_in) r_state <= DRAIN;
                  else           r_cnt   <= r_cnt + 1'b1;
               end else if (w_out_fire) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end
            end
            DRAIN: begin
               if (w_out_fire && r_out_last) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_line   = r_out_line;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_last   = r_out_last;
   assign bus.slice_idx  = r_slice_idx;
   assign bus.busy       = (r_state == RUN) || (r_state == DRAIN);
   assign bus.frame_done = (r_state == DONE);

endmodule

// File: tb/tb_slice_chi_stage.sv
// Self-checking bench for slice_chi_stage: directed vectors, full frames with random data,
// backpressure, protocol abuse and mid-frame reset, checked against a row/column chi model.
module tb_slice_chi_stage;
   import chi_pkg::*;

   localparam int SLICES = 64;
   localparam int CNT_W  = 6;

   logic clk = 1'b0;
   logic rst;
`ifdef CHI_IOTA_EN
   logic [63:0] rc;
`endif

   slice_chi_stage_if #(.CNT_W(CNT_W)) bus ();

   slice_chi_stage #(.SLICES(SLICES), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
`ifdef CHI_IOTA_EN
      .rc  (rc),
`endif
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [24:0] frame_data [SLICES];
   logic [24:0] kvec_in    [4];
   logic [24:0] kvec_out   [4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: view the slice as a 5x5 grid of rows and columns and apply the row rule directly.
   function automatic logic [24:0] ref_chi(input logic [24:0] a, input int z);
      bit          p [5][5];
      bit          q [5][5];
      logic [24:0] res;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            p[r][c] = a[5*r + c];
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            q[r][c] = p[r][c] ^ (!p[r][(c + 1) % 5] && p[r][(c + 2) % 5]);
`ifdef CHI_IOTA_EN
      q[2][2] = q[2][2] ^ rc[z];
`endif
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            res[5*r + c] = q[r][c];
      return res;
   endfunction

   task automatic run_frame(input bit rand_valid, input bit rand_ready, input int stall_at,
                            input int stall_len, input int abuse_at, input int abort_after,
                            input bit directed, input int iota_z);
      logic [24:0]      exp_q [$];
      int               idx_q [$];
      int               sent = 0, got = 0, cyc = 0, stalled = 0;
      int               first_in = -1, first_out = -1, last_out = -1;
      bit               stall, abused = 1'b0;
      logic [24:0]      snap_line, e_line;
      logic [CNT_W-1:0] snap_idx;
      int               e_idx;

      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1);

      while (got < SLICES && cyc < 4000) begin
         bus.start    = (sent == abuse_at) && !abused;
         abused       = abused || bus.start;
         bus.in_valid = (sent < SLICES) && (!rand_valid || $urandom_range(0, 3) != 0);
         bus.in_line  = (sent < SLICES) ? frame_data[sent] : 25'($urandom);
         stall        = (got == stall_at) && (stalled < stall_len);
         bus.out_ready = stall ? 1'b0 : (!rand_ready || $urandom_range(0, 3) != 0);
         #1;
         check("in_ready", bus.in_ready, (sent < SLICES) && (!bus.out_valid || bus.out_ready));
         if (stall) begin
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
            if (stalled == 0) begin
               snap_line = bus.out_line;
               snap_idx  = bus.slice_idx;
            end else begin
               check("stall_line_stable", bus.out_line, snap_line);
               check("stall_idx_stable", bus.slice_idx, snap_idx);
            end
            stalled++;
         end
         if (bus.out_valid && bus.out_ready) begin
            check("output_has_source", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e_line = exp_q.pop_front();
               e_idx  = idx_q.pop_front();
               check("out_line", bus.out_line, e_line);
               check("slice_idx", bus.slice_idx, e_idx);
               check("out_last", bus.out_last, e_idx == SLICES - 1);
               if (directed && e_idx < 4) check("vector", bus.out_line, kvec_out[e_idx]);
               if (iota_z >= 0) check("iota_slice", bus.out_line, (e_idx == iota_z) ? 25'h0001000 : 25'h0);
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_chi(frame_data[sent], sent));
            idx_q.push_back(sent);
            if (first_in < 0) first_in = cyc;
            sent++;
         end
         if (abort_after > 0 && sent == abort_after) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         cyc++;
      end

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("frame_complete", got, SLICES);
      check("queue_empty", exp_q.size(), 0);
      if (!rand_valid && !rand_ready && stall_len == 0) begin
         check("first_latency", first_out - first_in, 1);
         check("back_to_back", last_out - first_out, SLICES - 1);
      end
      #1;
      check("frame_done_pulse", bus.frame_done, 1);
      check("done_out_valid", bus.out_valid, 0);
      check("done_busy", bus.busy, 0);
      @(negedge clk); #1;
      check("frame_done_cleared", bus.frame_done, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_in_ready", bus.in_ready, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < SLICES; i++) frame_data[i] = 25'($urandom);
   endtask

   initial begin
      kvec_in  = '{25'h0000001, 25'h0000004, 25'h0000000, 25'h1FFFFFF};
      kvec_out = '{25'h0000009, 25'h0000005, 25'h0000000, 25'h1FFFFFF};
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.in_line   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
`ifdef CHI_IOTA_EN
      rc = 64'h0;
`endif

      // Reset state.
      @(negedge clk); @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_line", bus.out_line, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_slice_idx", bus.slice_idx, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_in_ready", bus.in_ready, 0);
      rst = 1'b1;

      // in_valid while idle must be ignored.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_line  = 25'($urandom);
         #1;
         check("idle_in_ready_abuse", bus.in_ready, 0);
         check("idle_out_valid_abuse", bus.out_valid, 0);
      end
      bus.in_valid = 1'b0;

      // Directed vectors at the head of a back-to-back frame.
      fill_random();
      for (int i = 0; i < 4; i++) frame_data[i] = kvec_in[i];
      run_frame(1'b0, 1'b0, -1, 0, -1, 0, 1'b1, -1);

      // Backpressure mid-frame plus a start pulse while running.
      fill_random();
      run_frame(1'b0, 1'b0, 20, 5, 10, 0, 1'b0, -1);

      // Random valid and ready.
      fill_random();
      run_frame(1'b1, 1'b1, -1, 0, -1, 0, 1'b0, -1);

      // Reset after slice 30 is accepted.
      fill_random();
      run_frame(1'b0, 1'b0, -1, 0, -1, 31, 1'b0, -1);
      rst = 1'b0;
      #1;
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_out_line", bus.out_line, 0);
      check("abort_out_last", bus.out_last, 0);
      check("abort_slice_idx", bus.slice_idx, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_frame_done", bus.frame_done, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("post_abort_no_done", bus.frame_done, 0);
         check("post_abort_idle", bus.busy, 0);
      end

      fill_random();
      run_frame(1'b0, 1'b1, -1, 0, -1, 0, 1'b0, -1);

`ifdef CHI_IOTA_EN
      for (int i = 0; i < SLICES; i++) frame_data[i] = '0;
      rc = 64'h0000000000000001;
      run_frame(1'b0, 1'b0, -1, 0, -1, 0, 1'b0, 0);
      rc = 64'h8000000000000000;
      run_frame(1'b0, 1'b0, -1, 0, -1, 0, 1'b0, 63);
      rc = {$urandom, $urandom};
      fill_random();
      run_frame(1'b1, 1'b1, -1, 0, -1, 0, 1'b0, -1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
